// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Memory-access stage of the MIPS pipeline, sitting after execute. ALU
// results pass straight through to writeback with one cycle of latency.
// Aligned LW/SW issue one request on the data bus and hold the upstream
// pipeline until the bus answers or the request times out.
//
// Handshakes:
//   upstream : an instruction is taken on any rising edge where
//              in_valid && in_ready && !flush. in_ready is high only in IDLE.
//   data bus : dreq_valid and all dreq_* fields stay stable from the cycle
//              after acceptance until the cycle where dresp_data_ok is high.
//              The bus finishes the request in that cycle, and dreq_valid
//              drops at the same clock edge.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   in_*                        instruction from execute, in_ready back-pressure
//   flush                       kill the instruction held in this stage
//   dreq_*                      data-bus request (addr, byte strobes, store data)
//   dresp_data_ok, dresp_data   data-bus completion and load data
//   wb_*                        registered writeback entry, wb_valid is one pulse
//   stall                       inverse of in_ready
//   dbg_state                   current FSM state (0 IDLE, 1 WAIT)
module mem_access_stage #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic              in_reg_write,
  input  logic [4:0]        in_wa,
  input  logic [ADDR_W-1:0] in_alu_result,
  input  logic [ADDR_W-1:0] in_store_data,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [3:0]        dreq_strobe,
  output logic [ADDR_W-1:0] dreq_data,
  input  logic              dresp_data_ok,
  input  logic [ADDR_W-1:0] dresp_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_wa,
  output logic [ADDR_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_pc,
  output logic [1:0]        wb_exc,
  output logic              stall,
  output logic              dbg_state
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ALIGN   = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state_q, state_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [4:0]        wb_wa_q, wb_wa_d;
  logic [ADDR_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] wb_pc_q, wb_pc_d;
  logic [1:0]        wb_exc_q, wb_exc_d;

  logic              dreq_valid_q, dreq_valid_d;
  logic [ADDR_W-1:0] dreq_addr_q, dreq_addr_d;
  logic [3:0]        dreq_strobe_q, dreq_strobe_d;
  logic [ADDR_W-1:0] dreq_data_q, dreq_data_d;

  // Fields of the outstanding bus instruction, used when it retires.
  logic              pend_load_q, pend_load_d;
  logic              pend_reg_write_q, pend_reg_write_d;
  logic [4:0]        pend_wa_q, pend_wa_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  logic              killed_q, killed_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic fire, is_mem, misaligned, timed_out, kill_now;

  assign in_ready   = (state_q == S_IDLE);
  assign stall      = ~in_ready;
  assign dbg_state  = state_q;
  assign fire       = in_valid && in_ready && !flush;
  assign is_mem     = in_load || in_store;
  assign misaligned = (in_alu_result[1:0] != 2'b00);
  assign timed_out  = !dresp_data_ok && (cnt_q == CNT_LAST);
  // A flush arriving in the retiring cycle still kills the writeback.
  assign kill_now   = killed_q || flush;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fire && is_mem && !misaligned) state_d = S_WAIT;
      S_WAIT: if (dresp_data_ok || timed_out)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    wb_valid_d       = 1'b0;
    wb_reg_write_d   = wb_reg_write_q;
    wb_wa_d          = wb_wa_q;
    wb_data_d        = wb_data_q;
    wb_pc_d          = wb_pc_q;
    wb_exc_d         = wb_exc_q;
    dreq_valid_d     = dreq_valid_q;
    dreq_addr_d      = dreq_addr_q;
    dreq_strobe_d    = dreq_strobe_q;
    dreq_data_d      = dreq_data_q;
    pend_load_d      = pend_load_q;
    pend_reg_write_d = pend_reg_write_q;
    pend_wa_d        = pend_wa_q;
    pend_pc_d        = pend_pc_q;
    killed_d         = killed_q;
    cnt_d            = cnt_q;

    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        if (fire) begin
          if (!is_mem || misaligned) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = is_mem ? 1'b0 : in_reg_write;
            wb_wa_d        = in_wa;
            wb_data_d      = in_alu_result;
            wb_pc_d        = in_pc;
            wb_exc_d       = is_mem ? EXC_ALIGN : EXC_NONE;
          end else begin
            // load+store together is decoded as a load
            dreq_valid_d     = 1'b1;
            dreq_addr_d      = in_alu_result;
            dreq_strobe_d    = in_load ? 4'h0 : 4'hF;
            dreq_data_d      = in_store_data;
            pend_load_d      = in_load;
            pend_reg_write_d = in_reg_write;
            pend_wa_d        = in_wa;
            pend_pc_d        = in_pc;
            cnt_d            = '0;
          end
        end
      end
      S_WAIT: begin
        killed_d = kill_now;
        if (dresp_data_ok || timed_out) begin
          dreq_valid_d = 1'b0;
          killed_d     = 1'b0;
          // A killed instruction leaves the previous writeback untouched.
          if (!kill_now) begin
            wb_valid_d = 1'b1;
            wb_wa_d    = pend_wa_q;
            wb_pc_d    = pend_pc_q;
            if (dresp_data_ok) begin
              wb_exc_d       = EXC_NONE;
              wb_reg_write_d = pend_load_q && pend_reg_write_q;
              wb_data_d      = pend_load_q ? dresp_data : dreq_addr_q;
            end else begin
              wb_exc_d       = EXC_TIMEOUT;
              wb_reg_write_d = 1'b0;
              wb_data_d      = dreq_addr_q;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_wa_q          <= '0;
      wb_data_q        <= '0;
      wb_pc_q          <= '0;
      wb_exc_q         <= '0;
      dreq_valid_q     <= 1'b0;
      dreq_addr_q      <= '0;
      dreq_strobe_q    <= '0;
      dreq_data_q      <= '0;
      pend_load_q      <= 1'b0;
      pend_reg_write_q <= 1'b0;
      pend_wa_q        <= '0;
      pend_pc_q        <= '0;
      killed_q         <= 1'b0;
      cnt_q            <= '0;
    end else begin
      wb_valid_q       <= wb_valid_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_wa_q          <= wb_wa_d;
      wb_data_q        <= wb_data_d;
      wb_pc_q          <= wb_pc_d;
      wb_exc_q         <= wb_exc_d;
      dreq_valid_q     <= dreq_valid_d;
      dreq_addr_q      <= dreq_addr_d;
      dreq_strobe_q    <= dreq_strobe_d;
      dreq_data_q      <= dreq_data_d;
      pend_load_q      <= pend_load_d;
      pend_reg_write_q <= pend_reg_write_d;
      pend_wa_q        <= pend_wa_d;
      pend_pc_q        <= pend_pc_d;
      killed_q         <= killed_d;
      cnt_q            <= cnt_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_wa        = wb_wa_q;
  assign wb_data      = wb_data_q;
  assign wb_pc        = wb_pc_q;
  assign wb_exc       = wb_exc_q;
  assign dreq_valid   = dreq_valid_q;
  assign dreq_addr    = dreq_addr_q;
  assign dreq_strobe  = dreq_strobe_q;
  assign dreq_data    = dreq_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (TIMEOUT=4). Inputs change 1ns
// after each rising edge; outputs are checked 1ns after the edge or on the
// falling edge. A scoreboard queue holds the wb_data expected for every
// writeback pulse.
module tb_mem_access_stage;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_store;
  logic        in_reg_write;
  logic [4:0]  in_wa;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [31:0] in_pc;
  logic        flush;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_wa;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [1:0]  wb_exc;
  logic        stall;
  logic        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  mem_access_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_load       (in_load),
    .in_store      (in_store),
    .in_reg_write  (in_reg_write),
    .in_wa         (in_wa),
    .in_alu_result (in_alu_result),
    .in_store_data (in_store_data),
    .in_pc         (in_pc),
    .flush         (flush),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_wa         (wb_wa),
    .wb_data       (wb_data),
    .wb_pc         (wb_pc),
    .wb_exc        (wb_exc),
    .stall         (stall),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_load       = 1'b0;
    in_store      = 1'b0;
    in_reg_write  = 1'b0;
    in_wa         = '0;
    in_alu_result = '0;
    in_store_data = '0;
    in_pc         = '0;
    flush         = 1'b0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic rw, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc);
    in_valid      = 1'b1;
    in_load       = ld;
    in_store      = st;
    in_reg_write  = rw;
    in_wa         = wa;
    in_alu_result = alu;
    in_store_data = sd;
    in_pc         = pc;
  endtask

  // scoreboard: every wb_valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (resetn && wb_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected_wb", 32'(wb_valid), 32'd0);
      else                   check("sb_wb_data", wb_data, exp_q.pop_front());
    end
  end

  initial begin
    idle_inputs();
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    resetn        = 1'b0;
    repeat (2) step();

    check("rst_wb_valid",   32'(wb_valid),   32'd0);
    check("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_stall",      32'(stall),      32'd0);
    check("rst_wb_data",    wb_data,         32'd0);
    resetn = 1'b1;
    step();

    // ADD then a second ALU op back-to-back
    drive(1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_0010, 32'h0, 32'h0000_0400);
    exp_q.push_back(32'h0000_0010);
    step();
    check("add_wb_valid", 32'(wb_valid),     32'd1);
    check("add_wb_data",  wb_data,           32'h10);
    check("add_wb_wa",    32'(wb_wa),        32'd8);
    check("add_wb_rw",    32'(wb_reg_write), 32'd1);
    check("add_wb_pc",    wb_pc,             32'h400);
    check("add_in_ready", 32'(in_ready),     32'd1);
    drive(1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0020, 32'h0, 32'h0000_0404);
    exp_q.push_back(32'h0000_0020);
    step();
    check("b2b_wb_valid", 32'(wb_valid), 32'd1);
    check("b2b_wb_data",  wb_data,       32'h20);
    check("b2b_wb_wa",    32'(wb_wa),    32'd9);
    idle_inputs();
    step();
    check("pulse_end",    32'(wb_valid), 32'd0);
    check("hold_wb_data", wb_data,       32'h20);

    // LW 0x100, data_ok on the 3rd WAIT cycle
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0100, 32'h0, 32'h0000_0408);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    idle_inputs();
    check("lw_dreq_valid1", 32'(dreq_valid),  32'd1);
    check("lw_dreq_addr",   dreq_addr,        32'h100);
    check("lw_strobe",      32'(dreq_strobe), 32'h0);
    check("lw_stall",       32'(stall),       32'd1);
    check("lw_in_ready",    32'(in_ready),    32'd0);
    check("lw_dbg_state",   32'(dbg_state),   32'd1);
    step();
    check("lw_dreq_valid2", 32'(dreq_valid), 32'd1);
    step();
    check("lw_dreq_valid3", 32'(dreq_valid), 32'd1);
    check("lw_wb_quiet",    32'(wb_valid),   32'd0);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'hDEAD_BEEF;
    step();
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    check("lw_wb_valid",   32'(wb_valid),     32'd1);
    check("lw_wb_data",    wb_data,           32'hDEAD_BEEF);
    check("lw_wb_rw",      32'(wb_reg_write), 32'd1);
    check("lw_wb_wa",      32'(wb_wa),        32'd3);
    check("lw_wb_exc",     32'(wb_exc),       32'd0);
    check("lw_dreq_drop",  32'(dreq_valid),   32'd0);
    check("lw_ready_back", 32'(in_ready),     32'd1);

    // SW 0x204, data_ok on the 1st WAIT cycle
    drive(1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0204, 32'h1234_5678, 32'h0000_040C);
    exp_q.push_back(32'h0000_0204);
    step();
    idle_inputs();
    check("sw_dreq_valid", 32'(dreq_valid),  32'd1);
    check("sw_strobe",     32'(dreq_strobe), 32'hF);
    check("sw_dreq_data",  dreq_data,        32'h1234_5678);
    check("sw_dreq_addr",  dreq_addr,        32'h204);
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0;
    check("sw_wb_valid", 32'(wb_valid),     32'd1);
    check("sw_wb_rw",    32'(wb_reg_write), 32'd0);
    check("sw_wb_exc",   32'(wb_exc),       32'd0);

    // misaligned LW 0x102
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0102, 32'h0, 32'h0000_0410);
    exp_q.push_back(32'h0000_0102);
    step();
    idle_inputs();
    check("mis_dreq_valid", 32'(dreq_valid),   32'd0);
    check("mis_wb_valid",   32'(wb_valid),     32'd1);
    check("mis_wb_exc",     32'(wb_exc),       32'd1);
    check("mis_wb_rw",      32'(wb_reg_write), 32'd0);
    check("mis_in_ready",   32'(in_ready),     32'd1);

    // LW 0x300 with no response: times out after 4 WAIT cycles
    drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0300, 32'h0, 32'h0000_0414);
    exp_q.push_back(32'h0000_0300);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check("to_dreq_held", 32'(dreq_valid), 32'd1);
      check("to_stall",     32'(stall),      32'd1);
      if (i < 3) step();
    end
    step();
    check("to_dreq_drop", 32'(dreq_valid),   32'd0);
    check("to_wb_valid",  32'(wb_valid),     32'd1);
    check("to_wb_exc",    32'(wb_exc),       32'd2);
    check("to_wb_rw",     32'(wb_reg_write), 32'd0);
    check("to_in_ready",  32'(in_ready),     32'd1);

    // LW 0x400 flushed during WAIT: bus completes, no writeback
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0400, 32'h0, 32'h0000_0418);
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_dreq_still", 32'(dreq_valid), 32'd1);
    step();
    dresp_data_ok = 1'b1;
    dresp_data    = 32'h5555_5555;
    step();
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    check("fl_no_wb",     32'(wb_valid),   32'd0);
    check("fl_dreq_drop", 32'(dreq_valid), 32'd0);
    check("fl_in_ready",  32'(in_ready),   32'd1);
    check("fl_wb_hold",   wb_data,         32'h300);

    // flush in IDLE blocks acceptance
    drive(1'b0, 1'b0, 1'b1, 5'd10, 32'h0000_0044, 32'h0, 32'h0000_041C);
    flush = 1'b1;
    step();
    idle_inputs();
    check("fli_no_wb",   32'(wb_valid),   32'd0);
    check("fli_no_dreq", 32'(dreq_valid), 32'd0);

    // reset asserted mid-WAIT
    drive(1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_0500, 32'h0, 32'h0000_0420);
    step();
    idle_inputs();
    check("rw_dreq_valid", 32'(dreq_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("rw_dreq_valid0", 32'(dreq_valid),   32'd0);
    check("rw_dreq_addr0",  dreq_addr,         32'd0);
    check("rw_wb_data0",    wb_data,           32'd0);
    check("rw_wb_wa0",      32'(wb_wa),        32'd0);
    check("rw_wb_pc0",      wb_pc,             32'd0);
    check("rw_wb_exc0",     32'(wb_exc),       32'd0);
    check("rw_wb_rw0",      32'(wb_reg_write), 32'd0);
    check("rw_in_ready",    32'(in_ready),     32'd1);
    step();
    resetn = 1'b1;
    repeat (2) step();
    check("rw_no_wb", 32'(wb_valid), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
